// File: rtl/r2sdf_bf_stage8.sv
// Radix-2 SDF (DIF) butterfly stage for the delay-8 position of a 32-point FFT.
// Drives an external 8-deep delay line and rotates the stored differences by W16^k.
module r2sdf_bf_stage8 #(
  parameter int unsigned DW   = 19,
  parameter int unsigned TW_W = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic signed [DW-1:0]   i_in_r,
  input  logic signed [DW-1:0]   i_in_i,
  input  logic signed [DW-1:0]   i_sr_out_r,
  input  logic signed [DW-1:0]   i_sr_out_i,
  output logic signed [DW-1:0]   o_sr_in_r,
  output logic signed [DW-1:0]   o_sr_in_i,
  output logic [2:0]             o_tw_idx,
  input  logic signed [TW_W-1:0] i_tw_r,
  input  logic signed [TW_W-1:0] i_tw_i,
  output logic                   o_out_valid,
  output logic signed [DW-1:0]   o_out_r,
  output logic signed [DW-1:0]   o_out_i,
  output logic                   o_out_first,
  output logic                   o_err
);

  localparam int unsigned PW = DW + TW_W + 1;
  localparam logic signed [PW-1:0] SatMax  = (PW'(1) <<< (DW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SatMin  = -SatMax - PW'(1);
  localparam logic signed [PW-1:0] RndHalf = PW'(1) <<< (TW_W - 3);

  typedef enum logic [1:0] {StFirst, StSecond, StDrain} state_e;

  state_e            r_state, w_state_d;
  logic [2:0]        r_k, w_k_d;
  logic              r_pend, w_pend_d;
  logic              r_out_valid, w_out_valid_d;
  logic signed [DW-1:0] r_out_r, r_out_i, w_out_r_d, w_out_i_d;
  logic              r_out_first, w_out_first_d;
  logic              r_err, w_err_d;

  // Butterfly at DW+1 bits; dropping the LSB is the floor halving.
  logic signed [DW:0] w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  assign w_sum_r = {i_sr_out_r[DW-1], i_sr_out_r} + {i_in_r[DW-1], i_in_r};
  assign w_sum_i = {i_sr_out_i[DW-1], i_sr_out_i} + {i_in_i[DW-1], i_in_i};
  assign w_dif_r = {i_sr_out_r[DW-1], i_sr_out_r} - {i_in_r[DW-1], i_in_r};
  assign w_dif_i = {i_sr_out_i[DW-1], i_sr_out_i} - {i_in_i[DW-1], i_in_i};

  logic signed [PW-1:0] w_dr, w_di, w_twr, w_twi, w_re, w_im, w_re_sh, w_im_sh;
  logic signed [DW-1:0] w_rot_r, w_rot_i;
  assign w_dr    = PW'(i_sr_out_r);
  assign w_di    = PW'(i_sr_out_i);
  assign w_twr   = PW'(i_tw_r);
  assign w_twi   = PW'(i_tw_i);
  assign w_re    = w_dr * w_twr - w_di * w_twi;
  assign w_im    = w_dr * w_twi + w_di * w_twr;
  assign w_re_sh = (w_re + RndHalf) >>> (TW_W - 2);
  assign w_im_sh = (w_im + RndHalf) >>> (TW_W - 2);

  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] c;
    if (v > SatMax)      c = SatMax;
    else if (v < SatMin) c = SatMin;
    else                 c = v;
    return c[DW-1:0];
  endfunction

  assign w_rot_r = sat(w_re_sh);
  assign w_rot_i = sat(w_im_sh);

  always_comb begin
    w_state_d     = r_state;
    w_k_d         = r_k;
    w_pend_d      = r_pend;
    w_out_valid_d = 1'b0;
    w_out_r_d     = w_rot_r;
    w_out_i_d     = w_rot_i;
    w_out_first_d = 1'b0;
    w_err_d       = 1'b0;
    o_in_ready    = 1'b1;
    o_sr_in_r     = '0;
    o_sr_in_i     = '0;
    o_tw_idx      = r_k;
    unique case (r_state)
      StFirst: begin
        if (i_in_valid) begin
          o_sr_in_r     = i_in_r;
          o_sr_in_i     = i_in_i;
          w_out_valid_d = r_pend;
          w_k_d         = r_k + 3'd1;
          if (r_k == 3'd7) w_state_d = StSecond;
        end else if (r_k == 3'd0) begin
          if (r_pend) begin
            w_out_valid_d = 1'b1;
            w_k_d         = 3'd1;
            w_state_d     = StDrain;
          end
        end else begin
          w_err_d  = 1'b1;
          w_k_d    = 3'd0;
          w_pend_d = 1'b0;
        end
      end
      StSecond: begin
        if (i_in_valid) begin
          w_out_valid_d = 1'b1;
          w_out_r_d     = w_sum_r[DW:1];
          w_out_i_d     = w_sum_i[DW:1];
          w_out_first_d = (r_k == 3'd0);
          o_sr_in_r     = w_dif_r[DW:1];
          o_sr_in_i     = w_dif_i[DW:1];
          w_k_d         = r_k + 3'd1;
          if (r_k == 3'd7) begin
            w_state_d = StFirst;
            w_pend_d  = 1'b1;
          end
        end else begin
          w_err_d   = 1'b1;
          w_k_d     = 3'd0;
          w_pend_d  = 1'b0;
          w_state_d = StFirst;
        end
      end
      StDrain: begin
        o_in_ready    = 1'b0;
        w_out_valid_d = 1'b1;
        w_k_d         = r_k + 3'd1;
        if (r_k == 3'd7) begin
          w_state_d = StFirst;
          w_pend_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = StFirst;
        w_k_d     = 3'd0;
        w_pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StFirst;
      r_k         <= 3'd0;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_first <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_k         <= w_k_d;
      r_pend      <= w_pend_d;
      r_out_valid <= w_out_valid_d;
      r_out_first <= w_out_first_d;
      r_err       <= w_err_d;
      if (w_out_valid_d) begin
        r_out_r <= w_out_r_d;
        r_out_i <= w_out_i_d;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_r     = r_out_r;
  assign o_out_i     = r_out_i;
  assign o_out_first = r_out_first;
  assign o_err       = r_err;

endmodule

// File: tb/tb_r2sdf_bf_stage8.sv
// Scoreboard bench for r2sdf_bf_stage8: block-level reference model, external delay line
// and twiddle ROM modelled here.
module tb_r2sdf_bf_stage8;
  localparam int DW   = 19;
  localparam int TW_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [DW-1:0]   in_r = '0, in_i = '0;
  logic signed [DW-1:0]   sr_out_r, sr_out_i, sr_in_r, sr_in_i;
  logic [2:0]             tw_idx;
  logic signed [TW_W-1:0] tw_r, tw_i;
  logic                   out_valid, out_first, err;
  logic signed [DW-1:0]   out_r, out_i;

  r2sdf_bf_stage8 #(.DW(DW), .TW_W(TW_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_r(in_r), .i_in_i(in_i), .i_sr_out_r(sr_out_r), .i_sr_out_i(sr_out_i),
    .o_sr_in_r(sr_in_r), .o_sr_in_i(sr_in_i), .o_tw_idx(tw_idx),
    .i_tw_r(tw_r), .i_tw_i(tw_i), .o_out_valid(out_valid), .o_out_r(out_r),
    .o_out_i(out_i), .o_out_first(out_first), .o_err(err)
  );

  // External 8-deep delay line, shifting every clock.
  logic signed [DW-1:0] sr_r [8];
  logic signed [DW-1:0] sr_i [8];
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      sr_r[i] <= sr_r[i-1];
      sr_i[i] <= sr_i[i-1];
    end
    sr_r[0] <= sr_in_r;
    sr_i[0] <= sr_in_i;
  end
  assign sr_out_r = sr_r[7];
  assign sr_out_i = sr_i[7];

  // W16^k = cos(2pi k/16) - j sin(2pi k/16), scaled by 1024 and rounded.
  int rom_r [8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
  int rom_i [8] = '{0, -392, -724, -946, -1024, -946, -724, -392};
  assign tw_r = TW_W'(rom_r[tw_idx]);
  assign tw_i = TW_W'(rom_i[tw_idx]);

  typedef struct {longint r; longint i; bit first;} samp_t;
  samp_t  exp_q[$];
  samp_t  pend_q[$];
  longint blk_r [8];
  longint blk_i [8];
  int     pos = 0;
  int     n_chk = 0, n_err = 0;
  int     err_exp = 0, err_seen = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    longint mx = (longint'(1) <<< (DW - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  function automatic samp_t rot(input longint dr, input longint di, input int k);
    samp_t s;
    longint re = dr * rom_r[k] - di * rom_i[k];
    longint im = dr * rom_i[k] + di * rom_r[k];
    s.r = sat((re + (longint'(1) <<< (TW_W - 3))) >>> (TW_W - 2));
    s.i = sat((im + (longint'(1) <<< (TW_W - 3))) >>> (TW_W - 2));
    s.first = 1'b0;
    return s;
  endfunction

  // Reference: 16-sample blocks; first half buffered, second half makes sums now and
  // rotated differences that leave during the next block's first half (or a drain).
  function automatic void model_accept(input longint xr, input longint xi);
    samp_t s;
    if (pos < 8) begin
      blk_r[pos] = xr;
      blk_i[pos] = xi;
      if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    end else begin
      s.r = (blk_r[pos-8] + xr) >>> 1;
      s.i = (blk_i[pos-8] + xi) >>> 1;
      s.first = (pos == 8);
      exp_q.push_back(s);
      pend_q.push_back(rot((blk_r[pos-8] - xr) >>> 1, (blk_i[pos-8] - xi) >>> 1, pos - 8));
    end
    pos = (pos + 1) % 16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint xr, input longint xi);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      in_valid = 1'b0;
      tick();
      guard++;
    end
    if (guard >= 40) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_r = DW'(xr);
    in_i = DW'(xi);
    tick();
    model_accept(xr, xi);
  endtask

  task automatic gap();
    in_valid = 1'b0;
    if (pos == 0) begin
      while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      tick();
      chk("no_err_on_idle", err, 0);
    end else begin
      pend_q.delete();
      pos = 0;
      err_exp++;
      tick();
      chk("err_pulse", err, 1);
      tick();
      chk("err_one_cycle", err, 0);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    pend_q.delete();
    pos = 0;
  endtask

  function automatic longint rnd();
    logic signed [DW-1:0] v;
    v = DW'($urandom);
    return longint'(v);
  endfunction

  always @(negedge clk) begin
    samp_t e;
    if (err) err_seen++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output actual=(%0d,%0d) required=none at %0t",
                 out_r, out_i, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_r", out_r, e.r);
        chk("out_i", out_i, e.i);
        chk("out_first", out_first, longint'(e.first));
      end
    end
  end

  initial begin
    // T1: reset mid-SECOND, then the next block's first half must be silent.
    do_reset();
    for (int n = 0; n < 12; n++) send(rnd(), rnd());
    do_reset();
    // T2: ramp block then a gapless random block; T3: drain with in_ready low.
    for (int n = 0; n < 16; n++) send(n, 0);
    for (int n = 0; n < 16; n++) send(rnd(), rnd());
    gap();
    for (int i = 0; i < 7; i++) begin
      chk("drain_in_ready", in_ready, 0);
      tick();
    end
    chk("idle_in_ready", in_ready, 1);
    repeat (4) gap();
    // T4: drop at FIRST k=3, then a clean block.
    for (int n = 0; n < 3; n++) send(rnd(), rnd());
    gap();
    for (int n = 0; n < 16; n++) send(rnd(), rnd());
    gap();
    repeat (9) gap();
    // Drops while differences are pending: mid-FIRST and mid-SECOND.
    for (int n = 0; n < 21; n++) send(rnd(), rnd());
    gap();
    for (int n = 0; n < 27; n++) send(rnd(), rnd());
    gap();
    // T5: saturation extremes in both directions.
    for (int n = 0; n < 8; n++) send(262143, 262143);
    for (int n = 0; n < 8; n++) send(-262144, -262144);
    for (int n = 0; n < 8; n++) send(-262144, 262143);
    for (int n = 0; n < 8; n++) send(262143, -262144);
    gap();
    repeat (9) gap();
    // T6: three gapless random blocks, output continuous once the first sum appears.
    do_reset();
    for (int n = 0; n < 48; n++) begin
      send(rnd(), rnd());
      if (n >= 8) chk("continuous_valid", out_valid, 1);
    end
    gap();
    repeat (10) gap();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("err_pulse_count", err_seen, err_exp);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
